// File: rtl/universal_shift_reg_burst.sv
// Parametrised universal shift register with rotate/arithmetic/clear modes,
// clock enable and a burst sequencer that repeats one shift-class op N times.
module universal_shift_reg_burst #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] I,
  input  logic             MSB_in,
  input  logic             LSB_in,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] A,
  output logic             so_right,
  output logic             so_left,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHR  = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_LOAD = 3'b011;
  localparam logic [2:0] M_ROR  = 3'b100;
  localparam logic [2:0] M_ROL  = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;
  localparam logic [2:0] M_CLR  = 3'b111;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [CNT_W-1:0] r_rem;
  logic [2:0]       r_mode;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_next_idle;
  logic [WIDTH-1:0] w_next_burst;
  logic             w_shift_req;

  function automatic logic is_shift_class(input logic [2:0] m);
    logic r;
    case (m)
      M_SHR, M_SHL, M_ROR, M_ROL, M_ASR: r = 1'b1;
      default:                           r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] apply_op(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] din,
    input logic             msb_in,
    input logic             lsb_in
  );
    logic [WIDTH-1:0] r;
    case (m)
      M_HOLD:  r = a;
      M_SHR:   r = {msb_in, a[WIDTH-1:1]};
      M_SHL:   r = {a[WIDTH-2:0], lsb_in};
      M_LOAD:  r = din;
      M_ROR:   r = {a[0], a[WIDTH-1:1]};
      M_ROL:   r = {a[WIDTH-2:0], a[WIDTH-1]};
      M_ASR:   r = {a[WIDTH-1], a[WIDTH-1:1]};
      M_CLR:   r = {WIDTH{1'b0}};
      default: r = a;
    endcase
    return r;
  endfunction

  // In BURST the latched mode drives the datapath; serial inputs stay live.
  assign w_next_idle  = apply_op(mode, r_a, I, MSB_in, LSB_in);
  assign w_next_burst = apply_op(r_mode, r_a, I, MSB_in, LSB_in);
  assign w_shift_req  = en & start & is_shift_class(mode);

  // Burst sequencer and shift register state.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_state <= IDLE;
      r_a     <= {WIDTH{1'b0}};
      r_rem   <= {CNT_W{1'b0}};
      r_mode  <= M_HOLD;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (w_shift_req) begin
            r_mode <= mode;
            if (count == {CNT_W{1'b0}}) begin
              r_done <= 1'b1;
            end else if (count == CNT_W'(1)) begin
              r_a    <= w_next_idle;
              r_done <= 1'b1;
            end else begin
              r_a     <= w_next_idle;
              r_rem   <= count - CNT_W'(1);
              r_busy  <= 1'b1;
              r_state <= BURST;
            end
          end else if (en) begin
            r_a <= w_next_idle;
          end else begin
            r_a <= r_a;
          end
        end
        BURST: begin
          r_a   <= w_next_burst;
          r_rem <= r_rem - CNT_W'(1);
          if (r_rem == CNT_W'(1)) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign A        = r_a;
  assign so_right = r_a[0];
  assign so_left  = r_a[WIDTH-1];
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_universal_shift_reg_burst.sv
// Directed-vector bench for universal_shift_reg_burst (WIDTH=8, CNT_W=4).
module tb_universal_shift_reg_burst;

  logic       clk;
  logic       clear;
  logic       en;
  logic [2:0] mode;
  logic [7:0] I;
  logic       MSB_in;
  logic       LSB_in;
  logic       start;
  logic [3:0] count;
  logic [7:0] A;
  logic       so_right;
  logic       so_left;
  logic       busy;
  logic       done;

  int n_vec;
  int n_err;

  universal_shift_reg_burst #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .clear(clear), .en(en), .mode(mode), .I(I),
    .MSB_in(MSB_in), .LSB_in(LSB_in), .start(start), .count(count),
    .A(A), .so_right(so_right), .so_left(so_left), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    en = 1'b1; start = 1'b0; mode = 3'b011; I = v;
    step();
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    clear = 1'b0; en = 1'b0; mode = 3'b000; I = 8'h00;
    MSB_in = 1'b0; LSB_in = 1'b0; start = 1'b0; count = 4'd0;
    #3;
    check_val("rst_A", 32'(A), 32'h00);
    check_val("rst_busy", 32'(busy), 32'h0);
    check_val("rst_done", 32'(done), 32'h0);
    @(negedge clk); clear = 1'b1;

    load(8'hA5);
    check_val("load_A5", 32'(A), 32'hA5);
    check_val("so_left", 32'(so_left), 32'h1);
    check_val("so_right", 32'(so_right), 32'h1);
    #2 clear = 1'b0;
    #1 check_val("async_clear", 32'(A), 32'h00);
    clear = 1'b1;

    load(8'hA5);
    mode = 3'b001; MSB_in = 1'b1; step();
    check_val("shr", 32'(A), 32'hD2);
    mode = 3'b010; LSB_in = 1'b0; step();
    check_val("shl", 32'(A), 32'hA4);
    mode = 3'b000;
    for (int k = 0; k < 3; k++) begin
      step();
      check_val("hold", 32'(A), 32'hA4);
    end
    en = 1'b0; mode = 3'b011; I = 8'h00; step();
    check_val("en_low", 32'(A), 32'hA4);

    load(8'h81); mode = 3'b100; step();
    check_val("ror", 32'(A), 32'hC0);
    load(8'h81); mode = 3'b101; step();
    check_val("rol", 32'(A), 32'h03);
    load(8'h90); mode = 3'b110; MSB_in = 1'b0; step();
    check_val("asr", 32'(A), 32'hC8);
    mode = 3'b111; step();
    check_val("sclr", 32'(A), 32'h00);

    // Burst of three rotate-lefts with distracting inputs after E0.
    load(8'h01);
    mode = 3'b101; count = 4'd3; start = 1'b1; step();
    check_val("b_e0_A", 32'(A), 32'h02);
    check_val("b_e0_busy", 32'(busy), 32'h1);
    check_val("b_e0_done", 32'(done), 32'h0);
    start = 1'b0; mode = 3'b011; I = 8'hFF; count = 4'd0; en = 1'b0; step();
    check_val("b_e1_A", 32'(A), 32'h04);
    check_val("b_e1_busy", 32'(busy), 32'h1);
    step();
    check_val("b_e2_A", 32'(A), 32'h08);
    check_val("b_e2_busy", 32'(busy), 32'h0);
    check_val("b_e2_done", 32'(done), 32'h1);
    step();
    check_val("b_e3_done", 32'(done), 32'h0);
    check_val("b_e3_A", 32'(A), 32'h08);

    // count=0 and count=1 edge cases.
    load(8'h3C);
    mode = 3'b001; MSB_in = 1'b0; count = 4'd0; start = 1'b1; step();
    check_val("c0_A", 32'(A), 32'h3C);
    check_val("c0_busy", 32'(busy), 32'h0);
    check_val("c0_done", 32'(done), 32'h1);
    start = 1'b0; mode = 3'b000; step();
    check_val("c0_done_clr", 32'(done), 32'h0);
    mode = 3'b001; count = 4'd1; start = 1'b1; step();
    check_val("c1_A", 32'(A), 32'h1E);
    check_val("c1_busy", 32'(busy), 32'h0);
    check_val("c1_done", 32'(done), 32'h1);
    start = 1'b0; mode = 3'b000; step();
    check_val("c1_done_clr", 32'(done), 32'h0);
    check_val("c1_hold", 32'(A), 32'h1E);

    // start held high: second burst begins on the first IDLE edge.
    load(8'h01);
    mode = 3'b010; LSB_in = 1'b0; count = 4'd2; start = 1'b1; step();
    check_val("rs_e0", 32'(A), 32'h02);
    step();
    check_val("rs_e1_A", 32'(A), 32'h04);
    check_val("rs_e1_done", 32'(done), 32'h1);
    step();
    check_val("rs_e2_A", 32'(A), 32'h08);
    check_val("rs_e2_busy", 32'(busy), 32'h1);
    check_val("rs_e2_done", 32'(done), 32'h0);
    start = 1'b0; LSB_in = 1'b1; step();
    check_val("rs_e3_A", 32'(A), 32'h11);
    check_val("rs_e3_done", 32'(done), 32'h1);

    // Abort a long burst with reset.
    load(8'hFF);
    mode = 3'b001; MSB_in = 1'b0; count = 4'd10; start = 1'b1; step();
    check_val("ab_e0", 32'(A), 32'h7F);
    start = 1'b0;
    step(); step(); step();
    check_val("ab_e3", 32'(A), 32'h0F);
    check_val("ab_busy", 32'(busy), 32'h1);
    #2 clear = 1'b0;
    #1;
    check_val("ab_A", 32'(A), 32'h00);
    check_val("ab_busy0", 32'(busy), 32'h0);
    check_val("ab_done0", 32'(done), 32'h0);
    @(negedge clk); clear = 1'b1; en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check_val("post_A", 32'(A), 32'h00);
      check_val("post_busy", 32'(busy), 32'h0);
      check_val("post_done", 32'(done), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
